// File: rtl/pilha_retorno_if.sv
// Bus bundle for the return-address stack: request side driven by the
// datapath (call/return logic), status side driven by the stack itself.
interface pilha_retorno_if #(
  parameter int BITS      = 16,
  parameter int PONT_BITS = 3
);

  // Requests and data toward the stack
  logic                 empilha;
  logic                 desempilha;
  logic                 limpa_erro;
  logic [BITS-1:0]      din;

  // Registered top-of-stack and status back to the datapath
  logic [BITS-1:0]      dout;
  logic [PONT_BITS:0]   ocupacao;
  logic                 vazia;
  logic                 cheia;
  logic                 erro;

  // Datapath side: issues push/pop, consumes the top of stack
  modport master (
    output empilha, desempilha, limpa_erro, din,
    input  dout, ocupacao, vazia, cheia, erro
  );

  // Stack side
  modport slave (
    input  empilha, desempilha, limpa_erro, din,
    output dout, ocupacao, vazia, cheia, erro
  );

endinterface

// File: rtl/pilha_retorno.sv
// Return-address stack (LIFO) for PC values. Calls push the current PC,
// returns pop it back. dout is a registered copy of the top of stack, so a
// consumer can read it in the same cycle it requests the pop.
module pilha_retorno #(
  parameter int BITS         = 16,
  parameter int PROFUNDIDADE = 8,   // power of two, at least 2
  parameter int PONT_BITS    = 3    // log2(PROFUNDIDADE)
) (
  input  logic          clock,
  input  logic          reset,      // asynchronous, active low
  pilha_retorno_if.slave bus
);

  // Occupancy is one bit wider than an array index so "full" is representable.
  localparam logic [PONT_BITS:0]   OCUP_MAX  = (PONT_BITS+1)'(PROFUNDIDADE);
  localparam logic [PONT_BITS:0]   OCUP_ZERO = '0;
  localparam logic [PONT_BITS:0]   OCUP_UM   = (PONT_BITS+1)'(1);
  localparam logic [PONT_BITS-1:0] IDX_UM    = PONT_BITS'(1);
  localparam logic [PONT_BITS-1:0] IDX_DOIS  = PONT_BITS'(2);

  // What the request pins ask for this cycle.
  typedef enum logic [1:0] {
    OP_NADA,
    OP_EMPILHA,
    OP_DESEMPILHA,
    OP_TROCA      // push and pop together: replace the top entry
  } op_t;

  logic [BITS-1:0]      mem [PROFUNDIDADE];

  logic [PONT_BITS:0]   ocup_q, ocup_d;
  logic [BITS-1:0]      dout_q, dout_d;
  logic                 erro_q, erro_d;

  op_t                  op;
  logic                 falha;        // overflow or underflow this cycle
  logic                 esc_en;
  logic [PONT_BITS-1:0] esc_end;
  logic [BITS-1:0]      esc_dado;

  // Index arithmetic is done modulo the depth: with N == PROFUNDIDADE the low
  // bits are 0, and 0-1 / 0-2 land on the correct top / below-top slots.
  logic [PONT_BITS-1:0] idx_livre;    // slot N, first free entry
  logic [PONT_BITS-1:0] idx_topo;     // slot N-1, current top
  logic [PONT_BITS-1:0] idx_abaixo;   // slot N-2, entry under the top
  logic [BITS-1:0]      abaixo_topo;

  assign idx_livre   = ocup_q[PONT_BITS-1:0];
  assign idx_topo    = idx_livre - IDX_UM;
  assign idx_abaixo  = idx_livre - IDX_DOIS;
  assign abaixo_topo = mem[idx_abaixo];

  // Classify the request pair into a single operation.
  always_comb begin
    unique case ({bus.empilha, bus.desempilha})
      2'b10:   op = OP_EMPILHA;
      2'b01:   op = OP_DESEMPILHA;
      2'b11:   op = OP_TROCA;
      default: op = OP_NADA;
    endcase
  end

  // Next-state for occupancy, top-of-stack copy, array write and error flag.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    ocup_d   = ocup_q;
    dout_d   = dout_q;
    esc_en   = 1'b0;
    esc_end  = idx_livre;
    esc_dado = bus.din;
    falha    = 1'b0;

    unique case (op)
      OP_EMPILHA: begin
        if (ocup_q == OCUP_MAX) begin
          falha = 1'b1;                   // overflow: nothing else moves
        end else begin
          esc_en  = 1'b1;
          esc_end = idx_livre;
          ocup_d  = ocup_q + OCUP_UM;
          dout_d  = bus.din;
        end
      end

      OP_DESEMPILHA: begin
        if (ocup_q == OCUP_ZERO) begin
          falha = 1'b1;                   // underflow: nothing else moves
        end else if (ocup_q == OCUP_UM) begin
          ocup_d = OCUP_ZERO;
          dout_d = '0;                    // stack becomes empty
        end else begin
          ocup_d = ocup_q - OCUP_UM;
          dout_d = abaixo_topo;           // expose the new top
        end
      end

      OP_TROCA: begin
        if (ocup_q == OCUP_ZERO) begin
          // Nothing to pop, so this degenerates to a plain push.
          esc_en  = 1'b1;
          esc_end = idx_livre;
          ocup_d  = OCUP_UM;
          dout_d  = bus.din;
        end else begin
          // Overwrite the top in place; legal even when full.
          esc_en  = 1'b1;
          esc_end = idx_topo;
          dout_d  = bus.din;
        end
      end

      default: ;                          // OP_NADA: hold everything
    endcase

    // A fresh error beats a clear requested in the same cycle.
    erro_d = falha | (erro_q & ~bus.limpa_erro);
  end

  // Control registers: occupancy, registered top of stack, sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      ocup_q <= '0;
      dout_q <= '0;
      erro_q <= 1'b0;
    end else begin
      ocup_q <= ocup_d;
      dout_q <= dout_d;
      erro_q <= erro_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clock) begin
    // NOTE: the array is deliberately not reset; occupancy alone decides
    // which entries are valid, so stale contents are never observed.
    if (esc_en) begin
      mem[esc_end] <= esc_dado;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.ocupacao = ocup_q;
  assign bus.vazia    = (ocup_q == OCUP_ZERO);
  assign bus.cheia    = (ocup_q == OCUP_MAX);
  assign bus.erro     = erro_q;

endmodule

// File: tb/tb_pilha_retorno.sv
// Bench for the return-address stack: directed scenarios followed by random
// traffic, all compared against a queue-based LIFO model.
module tb_pilha_retorno;

  localparam int BITS         = 16;
  localparam int PROFUNDIDADE = 8;
  localparam int PONT_BITS    = 3;

  logic clock;
  logic reset;

  pilha_retorno_if #(.BITS(BITS), .PONT_BITS(PONT_BITS)) bus ();

  pilha_retorno #(
    .BITS         (BITS),
    .PROFUNDIDADE (PROFUNDIDADE),
    .PONT_BITS    (PONT_BITS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: the stack is a queue, top at the back.
  logic [BITS-1:0] modelo [$];
  logic            m_erro;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the model says is visible now.
  task automatic check_all(input string tag);
    logic [31:0] topo;
    int          n;
    n    = modelo.size();
    topo = (n == 0) ? 32'h0 : 32'(modelo[n-1]);
    check({tag, ".dout"},     32'(bus.dout),     topo);
    check({tag, ".ocupacao"}, 32'(bus.ocupacao), 32'(n));
    check({tag, ".vazia"},    32'(bus.vazia),    32'(n == 0));
    check({tag, ".cheia"},    32'(bus.cheia),    32'(n == PROFUNDIDADE));
    check({tag, ".erro"},     32'(bus.erro),     32'(m_erro));
  endtask

  // LIFO semantics for one cycle's requests.
  task automatic modelo_passo(input logic e, input logic d, input logic l,
                              input logic [BITS-1:0] dado);
    int   n;
    logic ruim;
    n    = modelo.size();
    ruim = 1'b0;
    if (e && d) begin
      if (n == 0) modelo.push_back(dado);
      else        modelo[n-1] = dado;
    end else if (e) begin
      if (n == PROFUNDIDADE) ruim = 1'b1;
      else                   modelo.push_back(dado);
    end else if (d) begin
      if (n == 0) ruim = 1'b1;
      else        void'(modelo.pop_back());
    end
    if (ruim)   m_erro = 1'b1;
    else if (l) m_erro = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit after the rising edge.
  task automatic passo(input logic e, input logic d, input logic l,
                       input logic [BITS-1:0] dado, input string tag);
    @(negedge clock);
    bus.empilha    = e;
    bus.desempilha = d;
    bus.limpa_erro = l;
    bus.din        = dado;
    @(posedge clock);
    modelo_passo(e, d, l, dado);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic            e, d, l;
    logic [BITS-1:0] dado;

    bus.empilha    = 1'b0;
    bus.desempilha = 1'b0;
    bus.limpa_erro = 1'b0;
    bus.din        = '0;
    modelo.delete();
    m_erro = 1'b0;

    // Reset and idle
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) passo(1'b0, 1'b0, 1'b0, 16'h0, "idle");

    // Fill to full
    for (int i = 1; i <= 8; i++) passo(1'b1, 1'b0, 1'b0, 16'(i * 16), "fill");

    // Overflow leaves contents alone and raises the error
    passo(1'b1, 1'b0, 1'b0, 16'h00FF, "overflow");
    passo(1'b0, 1'b0, 1'b1, 16'h0, "clear_after_overflow");

    // Drain: 0x70 down to 0x10, then 0
    for (int i = 0; i < 8; i++) passo(1'b0, 1'b1, 1'b0, 16'h0, "drain");

    // Underflow on empty
    passo(1'b0, 1'b1, 1'b0, 16'h0, "underflow");
    passo(1'b0, 1'b0, 1'b1, 16'h0, "clear_after_underflow");

    // Replace top with push+pop, then pop back to the lower entry
    passo(1'b1, 1'b0, 1'b0, 16'h0100, "push_100");
    passo(1'b1, 1'b0, 1'b0, 16'h0200, "push_200");
    passo(1'b1, 1'b1, 1'b0, 16'h0300, "replace_300");
    passo(1'b0, 1'b1, 1'b0, 16'h0, "pop_after_replace");
    passo(1'b0, 1'b1, 1'b0, 16'h0, "pop_to_empty");

    // Push+pop on empty acts as a plain push, no error
    passo(1'b1, 1'b1, 1'b0, 16'h0005, "pushpop_empty");
    passo(1'b0, 1'b1, 1'b0, 16'h0, "pop_5");

    // Replace while full is legal
    for (int i = 0; i < 8; i++) passo(1'b1, 1'b0, 1'b0, 16'(16'hA000 + i), "refill");
    passo(1'b1, 1'b1, 1'b0, 16'hBEEF, "replace_full");
    passo(1'b0, 1'b1, 1'b0, 16'h0, "pop_after_replace_full");

    // Error beats clear in the same cycle
    for (int i = 0; i < 7; i++) passo(1'b0, 1'b1, 1'b0, 16'h0, "drain2");
    passo(1'b0, 1'b1, 1'b1, 16'h0, "err_vs_clear");
    passo(1'b0, 1'b0, 1'b1, 16'h0, "clear");

    // Asynchronous reset between edges with a push pending
    for (int i = 1; i <= 3; i++) passo(1'b1, 1'b0, 1'b0, 16'(16'h0C00 + i), "pre_reset");
    @(negedge clock);
    bus.empilha = 1'b1;
    bus.din     = 16'h0DDD;
    #2;
    reset = 1'b0;
    modelo.delete();
    m_erro = 1'b0;
    #1;
    check_all("async_reset_now");
    @(posedge clock);
    #1;
    check_all("async_reset_held");
    @(negedge clock);
    bus.empilha = 1'b0;
    reset = 1'b1;
    passo(1'b0, 1'b0, 1'b0, 16'h0, "after_reset");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      e    = ($urandom_range(0, 99) < 55);
      d    = ($urandom_range(0, 99) < 45);
      l    = ($urandom_range(0, 7) == 0);
      dado = 16'($urandom);
      passo(e, d, l, dado, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pilha_retorno.md
Name: pilha_retorno

Overview:
- Hardware return-address stack (LIFO) for the processor datapath.
- The call path pushes the current PC value. The return path pops and reads the stored value back, then loads it into the PC register.
- This is the reader/writer pair for PC values: the PC register produces addresses, and this block stores them and hands them back in reverse order.

Parameters:
BITS, 16, width of each stored word (PC width)
PROFUNDIDADE, 8, number of entries; must be a power of two, at least 2
PONT_BITS, 3, log2(PROFUNDIDADE); the occupancy counter is PONT_BITS+1 bits wide

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
empilha  input  1  push request, sampled on rising clock
desempilha  input  1  pop request, sampled on rising clock
limpa_erro  input  1  synchronous clear of the sticky error flag
din  input  BITS  word to push
dout  output  BITS  registered copy of the current top of stack
ocupacao  output  PONT_BITS+1  number of valid entries (0..PROFUNDIDADE)
vazia  output  1  1 when ocupacao == 0
cheia  output  1  1 when ocupacao == PROFUNDIDADE
erro  output  1  sticky flag: overflow or underflow occurred

Behaviour:
- Reset (reset = 0, asynchronous, takes priority over everything):
  - ocupacao = 0, dout = 0, erro = 0, vazia = 1, cheia = 0.
  - Storage array contents are not cleared and are don't-care.
  - Reset asserted mid-operation aborts any pending push/pop immediately.
- vazia and cheia are combinational decodes of ocupacao. The registered state is ocupacao, the array, dout and erro.
- All other updates happen on the rising clock edge while reset = 1. Per-cycle cases, with N = ocupacao before the edge:
  - Push only, N < PROFUNDIDADE: mem[N] <= din; N <= N+1; dout <= din.
  - Push only, N == PROFUNDIDADE (overflow): array, N and dout unchanged; erro <= 1.
  - Pop only, N >= 2: N <= N-1; dout <= mem[N-2].
  - Pop only, N == 1: N <= 0; dout <= 0.
  - Pop only, N == 0 (underflow): nothing changes except erro <= 1.
  - Push and pop together, N >= 1 (replace top): mem[N-1] <= din; N unchanged; dout <= din; no error, even when full.
  - Push and pop together, N == 0: treated as push only (N <= 1, dout <= din); no error.
  - Neither request: hold all state.
- Latency: dout, ocupacao and the flags reflect an operation on the cycle after the edge that performs it. Consumers read dout in the same cycle they assert desempilha (pop-then-use); the popped value is the dout visible before that edge.
- erro is sticky until cleared:
  - Cleared by limpa_erro = 1 at a clock edge.
  - If an overflow or underflow occurs in the same cycle as limpa_erro, the new error wins: erro = 1.
- No wrap-around of the array: ocupacao never exceeds PROFUNDIDADE and never goes below 0.

Test Plan:
- Reset and idle: drive reset = 0, then release and idle 3 cycles -> dout = 0, ocupacao = 0, vazia = 1, cheia = 0, erro = 0.
- Fill and drain: push 0x0010, 0x0020, ..., 0x0080 (8 pushes) -> cheia = 1, ocupacao = 8, dout = 0x0080. Then 8 pops -> dout reads 0x0070, 0x0060, ..., 0x0010, then 0; vazia = 1; erro stays 0.
- Overflow and underflow:
  - With the stack full, push 0x00FF -> ocupacao stays 8, dout stays 0x0080, erro = 1.
  - Pulse limpa_erro -> erro = 0.
  - On an empty stack, pop -> erro = 1, ocupacao stays 0.
- Simultaneous push and pop:
  - Stack holds 0x0100 and 0x0200; push 0x0300 with pop -> ocupacao = 2, dout = 0x0300. One more pop -> dout = 0x0100.
  - On an empty stack, push 0x0005 with pop -> ocupacao = 1, dout = 0x0005, erro = 0.
- Asynchronous reset mid-operation: assert reset between clock edges while 3 entries are held and a push is pending -> outputs go to their reset values immediately (before the next edge); the pending push is lost; after release, ocupacao = 0.
- Error versus clear priority: on an empty stack, apply pop and limpa_erro in the same cycle -> erro = 1.
